// File: rtl/us_frame_pkg.sv
// Shared types and helpers for the frame writer: state encoding, word width and header-word slicing.
package us_frame_pkg;

  localparam int unsigned WORD_W        = 32;
  localparam int unsigned HDR_MAX_WORDS = 64;
  localparam int unsigned HDR_MAX_W     = HDR_MAX_WORDS * WORD_W;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FHDR = 3'd1,
    ST_PHDR = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4
  } state_e;

  // Word idx of a zero-extended header concatenation, word 0 in the LSBs.
  function automatic logic [WORD_W-1:0] hdr_word(input logic [HDR_MAX_W-1:0] hdr,
                                                 input int unsigned idx);
    return hdr[idx*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/us_hdr_mux.sv
// Selects one 32-bit header word from {param, mw}; indices 0..MW-1 are frame header words.
module us_hdr_mux
  import us_frame_pkg::*;
#(
  parameter int unsigned MW_WORDS = 2,
  parameter int unsigned PW_WORDS = 4,
  parameter int unsigned IDX_W    = 3
) (
  input  logic [MW_WORDS*WORD_W-1:0] mw,
  input  logic [PW_WORDS*WORD_W-1:0] param,
  input  logic [IDX_W-1:0]           idx,
  output logic [WORD_W-1:0]          word_c
);

  localparam int unsigned CAT_W = (MW_WORDS + PW_WORDS) * WORD_W;

  logic [CAT_W-1:0] cat;

  assign cat    = {param, mw};
  assign word_c = hdr_word(HDR_MAX_W'(cat), 32'(idx));

endmodule

// File: rtl/us_frame_writer.sv
// Sequences frame header, parameter header and A-scan words into one bank of the frame RAM.
// Optional checksum word after each sub-channel when US_FRAME_CSUM_EN is defined.
module us_frame_writer
  import us_frame_pkg::*;
#(
  parameter int unsigned N_CH     = 8,
  parameter int unsigned MW_WORDS = 2,
  parameter int unsigned PW_WORDS = 4,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned LEN_W    = 11,
  localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int unsigned PTR_W   = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_sync,
  input  logic                       i_sub_sync,
  input  logic [CH_W-1:0]            i_sub_ch,
  input  logic [LEN_W-1:0]           i_scan_len,
  input  logic                       i_bank,
  input  logic [MW_WORDS*WORD_W-1:0] i_mw,
  input  logic [PW_WORDS*WORD_W-1:0] i_param,
  input  logic [WORD_W-1:0]          i_in_data,
  input  logic                       i_in_vld,
  output logic                       o_in_rdy,
  output logic [PTR_W:0]             o_wr_addr,
  output logic [WORD_W-1:0]          o_wr_data,
  output logic                       o_wr_en,
  output logic                       o_done,
  output logic [CH_W-1:0]            o_sub_ch,
  output logic                       o_ovf,
  output logic                       o_err
);

  localparam int unsigned IDX_W = $clog2(MW_WORDS + PW_WORDS + 1);
  localparam int unsigned CNT_W = (LEN_W > IDX_W) ? LEN_W : IDX_W;

`ifdef US_FRAME_CSUM_EN
  localparam state_e ST_AFTER_DATA = ST_CSUM;
`else
  localparam state_e ST_AFTER_DATA = ST_IDLE;
`endif

  state_e                     state_q, state_d;
  logic [PTR_W-1:0]           ptr_q, ptr_d;
  logic                       full_q, full_d;
  logic                       first_q, first_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [LEN_W-1:0]           len_q, len_d;
  logic [MW_WORDS*WORD_W-1:0] mw_q, mw_d;
  logic [PW_WORDS*WORD_W-1:0] param_q, param_d;
  logic [WORD_W-1:0]          csum_q, csum_d;
  logic [CH_W-1:0]            sub_ch_d;
  logic                       ovf_d, err_d, wr_en_d, in_rdy_d, done_d;
  logic [PTR_W:0]             wr_addr_d;
  logic [WORD_W-1:0]          wr_data_d;
  logic                       sel_vld;
  logic [WORD_W-1:0]          sel_word;
  logic [IDX_W-1:0]           hdr_idx;
  logic [WORD_W-1:0]          hdr_word_c;

  assign hdr_idx = (state_q == ST_FHDR) ? IDX_W'(cnt_q) : IDX_W'(MW_WORDS) + IDX_W'(cnt_q);

  us_hdr_mux #(
    .MW_WORDS (MW_WORDS),
    .PW_WORDS (PW_WORDS),
    .IDX_W    (IDX_W)
  ) u_hdr_mux (
    .mw     (mw_q),
    .param  (param_q),
    .idx    (hdr_idx),
    .word_c (hdr_word_c)
  );

  // Next-state, counters and write-port selection; sync/sub-sync preempt the running sequence.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    full_d    = full_q;
    first_d   = first_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    mw_d      = mw_q;
    param_d   = param_q;
    csum_d    = csum_q;
    sub_ch_d  = o_sub_ch;
    ovf_d     = o_ovf;
    err_d     = o_err;
    wr_en_d   = 1'b0;
    wr_addr_d = o_wr_addr;
    wr_data_d = o_wr_data;
    sel_vld   = 1'b0;
    sel_word  = '0;

    if (i_sync || i_sub_sync) begin
      if (i_sync) begin
        ptr_d   = '0;
        full_d  = 1'b0;
        first_d = 1'b1;
        ovf_d   = 1'b0;
        err_d   = 1'b0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      if (i_sub_sync) begin
        if (!i_sync && state_q != ST_IDLE) err_d = 1'b1;
        sub_ch_d = i_sub_ch;
        len_d    = i_scan_len;
        mw_d     = i_mw;
        param_d  = i_param;
        cnt_d    = '0;
        csum_d   = '0;
        state_d  = (i_sync || first_q) ? ST_FHDR : ST_PHDR;
      end
    end else begin
      case (state_q)
        ST_FHDR: begin
          sel_vld  = 1'b1;
          sel_word = hdr_word_c;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(MW_WORDS - 1)) begin
            cnt_d   = '0;
            first_d = 1'b0;
            state_d = ST_PHDR;
          end
        end
        ST_PHDR: begin
          sel_vld  = 1'b1;
          sel_word = hdr_word_c;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(PW_WORDS - 1)) begin
            cnt_d   = '0;
            state_d = (len_q == '0) ? ST_AFTER_DATA : ST_DATA;
          end
        end
        ST_DATA: begin
          if (i_in_vld && o_in_rdy) begin
            sel_vld  = 1'b1;
            sel_word = i_in_data;
            cnt_d    = cnt_q + 1'b1;
            if (CNT_W'(cnt_q + 1'b1) == CNT_W'(len_q)) state_d = ST_AFTER_DATA;
          end
        end
        ST_CSUM: begin
          sel_vld  = 1'b1;
          sel_word = csum_q;
          state_d  = ST_IDLE;
        end
        ST_IDLE: ;
        default: state_d = ST_IDLE;
      endcase

      // Dropped words still count toward the checksum; the pointer sticks at the last word.
      if (sel_vld) begin
        if (state_q != ST_CSUM) csum_d = csum_q + sel_word;
        if (full_q) begin
          ovf_d = 1'b1;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = {i_bank, ptr_q};
          wr_data_d = sel_word;
          if (ptr_q == PTR_W'(DEPTH - 1)) full_d = 1'b1;
          else                            ptr_d  = ptr_q + 1'b1;
        end
      end
    end

    in_rdy_d = (state_d == ST_DATA);
    done_d   = (state_d == ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      full_q    <= 1'b0;
      first_q   <= 1'b0;
      cnt_q     <= '0;
      len_q     <= '0;
      mw_q      <= '0;
      param_q   <= '0;
      csum_q    <= '0;
      o_sub_ch  <= '0;
      o_ovf     <= 1'b0;
      o_err     <= 1'b0;
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
      o_in_rdy  <= 1'b0;
      o_done    <= 1'b1;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      full_q    <= full_d;
      first_q   <= first_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      mw_q      <= mw_d;
      param_q   <= param_d;
      csum_q    <= csum_d;
      o_sub_ch  <= sub_ch_d;
      o_ovf     <= ovf_d;
      o_err     <= err_d;
      o_wr_en   <= wr_en_d;
      o_wr_addr <= wr_addr_d;
      o_wr_data <= wr_data_d;
      o_in_rdy  <= in_rdy_d;
      o_done    <= done_d;
    end
  end

endmodule

// File: tb/tb_us_frame_writer.sv
// Randomised bench for us_frame_writer against a word-list model of each frame.
module tb_us_frame_writer;

  localparam int unsigned N_CH  = 8;
  localparam int unsigned MW    = 2;
  localparam int unsigned PW    = 4;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned LEN_W = 11;
  localparam int unsigned CH_W  = 3;
  localparam int unsigned PTR_W = 5;
  localparam int unsigned AW    = PTR_W + 1;
`ifdef US_FRAME_CSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif

  logic              clk, rst_n;
  logic              i_sync, i_sub_sync, i_bank, i_in_vld;
  logic [CH_W-1:0]   i_sub_ch;
  logic [LEN_W-1:0]  i_scan_len;
  logic [MW*32-1:0]  i_mw;
  logic [PW*32-1:0]  i_param;
  logic [31:0]       i_in_data;
  logic              o_in_rdy, o_wr_en, o_done, o_ovf, o_err;
  logic [AW-1:0]     o_wr_addr;
  logic [31:0]       o_wr_data;
  logic [CH_W-1:0]   o_sub_ch;

  us_frame_writer #(
    .N_CH(N_CH), .MW_WORDS(MW), .PW_WORDS(PW), .DEPTH(DEPTH), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_sync(i_sync), .i_sub_sync(i_sub_sync),
    .i_sub_ch(i_sub_ch), .i_scan_len(i_scan_len), .i_bank(i_bank),
    .i_mw(i_mw), .i_param(i_param), .i_in_data(i_in_data), .i_in_vld(i_in_vld),
    .o_in_rdy(o_in_rdy), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_wr_en(o_wr_en), .o_done(o_done), .o_sub_ch(o_sub_ch), .o_ovf(o_ovf),
    .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Model: frame write counter, flags and the word list of the sub-channel in flight.
  int              mcount;
  bit              mfirst, movf, merr, busy;
  logic            mbank;
  logic [31:0]     cur_words[$];
  logic [AW+31:0]  exp_q[$];
  logic [AW+31:0]  act_q[$];
  logic [31:0]     last_wr;

  always @(negedge clk) begin
    if (rst_n && o_wr_en) begin
      act_q.push_back({o_wr_addr, o_wr_data});
      last_wr = o_wr_data;
    end
  end

  task automatic commit(input bit with_sum);
    logic [31:0] s;
    s = '0;
    foreach (cur_words[k]) s += cur_words[k];
    if (with_sum) cur_words.push_back(s);
    foreach (cur_words[k]) begin
      if (mcount < DEPTH) begin
        exp_q.push_back({mbank, PTR_W'(mcount), cur_words[k]});
        mcount++;
      end else begin
        movf = 1'b1;
      end
    end
    cur_words.delete();
  endtask

  task automatic compare_writes();
    logic [AW+31:0] a, e;
    check("wr_count", 64'(act_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      check("wr_addr", 64'(a[AW+31:32]), 64'(e[AW+31:32]));
      check("wr_data", 64'(a[31:0]), 64'(e[31:0]));
    end
    exp_q.delete();
    act_q.delete();
  endtask

  task automatic run_sub(input int ch, input int len, input int vld_pct,
                         input int abort_at, input bit do_sync, input bit fixed);
    int  cycles, acc, total;
    bit  saw_rdy, done_seen;
    @(posedge clk); #1;
    if (busy) begin
      commit(1'b0);
      if (!do_sync) merr = 1'b1;
    end
    if (do_sync) begin
      mcount = 0; mfirst = 1'b1; movf = 1'b0; merr = 1'b0;
      mbank  = 1'($urandom);
      i_bank = mbank;
    end
    i_sync     = do_sync;
    i_sub_sync = 1'b1;
    i_sub_ch   = CH_W'(ch);
    i_scan_len = LEN_W'(len);
    i_in_vld   = 1'b0;
    if (fixed) begin
      i_mw    = {32'd2, 32'd1};
      i_param = {32'd6, 32'd5, 32'd4, 32'd3};
    end else begin
      i_mw    = {$urandom, $urandom};
      i_param = {$urandom, $urandom, $urandom, $urandom};
    end
    if (mfirst) for (int k = 0; k < MW; k++) cur_words.push_back(i_mw[k*32 +: 32]);
    for (int k = 0; k < PW; k++) cur_words.push_back(i_param[k*32 +: 32]);
    mfirst = 1'b0;
    busy   = 1'b1;
    @(posedge clk); #1;
    i_sync = 1'b0; i_sub_sync = 1'b0;
    cycles = 0; acc = 0; saw_rdy = 1'b0; done_seen = 1'b0;
    while (cycles < 300) begin
      i_in_vld  = ($urandom_range(99) < vld_pct);
      i_in_data = fixed ? 32'(7 + acc) : $urandom;
      @(negedge clk);
      if (o_done) begin done_seen = 1'b1; break; end
      if (o_in_rdy) saw_rdy = 1'b1;
      if (i_in_vld && o_in_rdy) begin cur_words.push_back(i_in_data); acc++; end
      @(posedge clk); cycles++; #1;
      if (abort_at >= 0 && acc == abort_at) begin i_in_vld = 1'b0; return; end
    end
    i_in_vld = 1'b0;
    check("done_seen", 64'(done_seen), 64'd1);
    total = cur_words.size() + CSUM;
    commit(CSUM != 0);
    busy = 1'b0;
    if (vld_pct >= 100) check("done_cycles", 64'(cycles), 64'(total));
    if (len == 0) check("len0_rdy", 64'(saw_rdy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    compare_writes();
    check("done", 64'(o_done), 64'd1);
    check("rdy_idle", 64'(o_in_rdy), 64'd0);
    check("sub_ch", 64'(o_sub_ch), 64'(ch));
    check("ovf", 64'(o_ovf), 64'(movf));
    check("err", 64'(o_err), 64'(merr));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_done"}, 64'(o_done), 64'd1);
    check({tag, "_rdy"},  64'(o_in_rdy), 64'd0);
    check({tag, "_wren"}, 64'(o_wr_en), 64'd0);
    check({tag, "_addr"}, 64'(o_wr_addr), 64'd0);
    check({tag, "_data"}, 64'(o_wr_data), 64'd0);
    check({tag, "_subch"}, 64'(o_sub_ch), 64'd0);
    check({tag, "_ovf"},  64'(o_ovf), 64'd0);
    check({tag, "_err"},  64'(o_err), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; i_sync = 1'b0; i_sub_sync = 1'b0; i_sub_ch = '0; i_scan_len = '0;
    i_bank = 1'b0; i_mw = '0; i_param = '0; i_in_data = '0; i_in_vld = 1'b0;
    mcount = 0; mfirst = 1'b0; movf = 1'b0; merr = 1'b0; busy = 1'b0; mbank = 1'b0;
    last_wr = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    rst_n = 1'b1;

    // Frame with headers, then a second sub-channel without frame header, then empty scan.
    run_sub(3, 4, 100, -1, 1'b1, 1'b0);
    run_sub(5, 2, 100, -1, 1'b0, 1'b0);
    run_sub(1, 0, 100, -1, 1'b0, 1'b0);

    // Bank overflow, then a bare sync clears it.
    run_sub(2, 40, 100, -1, 1'b1, 1'b0);
    @(posedge clk); #1;
    i_sync = 1'b1;
    @(posedge clk); #1;
    i_sync = 1'b0;
    mcount = 0; mfirst = 1'b1; movf = 1'b0; merr = 1'b0;
    check("sync_ovf", 64'(o_ovf), 64'd0);
    check("sync_done", 64'(o_done), 64'd1);

    // Aborts: restart while busy flags error; sync together with sub-sync clears it.
    run_sub(2, 5, 100, 2, 1'b0, 1'b0);
    run_sub(4, 3, 80, -1, 1'b0, 1'b0);
    run_sub(6, 4, 100, 1, 1'b0, 1'b0);
    run_sub(7, 2, 100, -1, 1'b1, 1'b0);

    // Known headers 1..6 and data 7,8 with gapped valid.
    run_sub(0, 2, 50, -1, 1'b1, 1'b1);
    check("fixed_last", 64'(last_wr), (CSUM != 0) ? 64'd36 : 64'd8);

    for (int f = 0; f < 5; f++) begin
      for (int s = 0; s < 3; s++) begin
        run_sub(int'($urandom_range(N_CH - 1)), int'($urandom_range(7)),
                int'($urandom_range(100, 40)), -1, (s == 0), 1'b0);
      end
    end

    // Reset in the middle of a data phase.
    run_sub(5, 6, 100, 3, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    act_q.delete(); exp_q.delete(); cur_words.delete();
    mcount = 0; mfirst = 1'b0; movf = 1'b0; merr = 1'b0; busy = 1'b0;
    run_sub(3, 3, 100, -1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
